// File: rtl/mem_loader_pkg.sv
// Shared definitions for the image loader: FSM encoding and stream header layout.
package mem_loader_pkg;

    typedef enum logic [2:0] {
        StIdle,
        StLen,
        StData,
        StFlush,
        StDone
    } state_e;

    // HEADER word fields
    localparam int unsigned TGT_BIT  = 15;
    localparam int unsigned AUTO_BIT = 14;
    localparam int unsigned RSVD_HI  = 13;
    localparam int unsigned RSVD_LO  = 8;

    // Target select values
    localparam logic TGT_IMEM = 1'b0;
    localparam logic TGT_DMEM = 1'b1;

    // A header is usable only when every reserved bit is zero.
    function automatic logic hdr_ok(input logic [15:0] w);
        return ~|w[RSVD_HI:RSVD_LO];
    endfunction

endpackage

// File: rtl/mem_loader.sv
// Streams HEADER, COUNT and N data words from the host into imem or dmem.
// It holds the processor disabled during the load and can pulse its start input afterwards.
module mem_loader
    import mem_loader_pkg::*;
#(
    parameter int unsigned DATA_W = 16,
    parameter int unsigned ADDR_W = 8
) (
    input  logic              clock,
    input  logic              reset,
    input  logic [DATA_W-1:0] in_data,
    input  logic              in_valid,
    output logic              in_ready,
    output logic              imem_we,
    output logic              dmem_we,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              proc_enable,
    output logic              proc_start,
    output logic              busy,
    output logic              err
);

    state_e            state_q, state_d;
    logic              alive_q;
    logic              tgt_q;
    logic              auto_q;
    logic [ADDR_W-1:0] addr_q;
    logic [ADDR_W:0]   cnt_q;      // one extra bit so N=256 fits
    logic              imem_we_q, dmem_we_q;
    logic [ADDR_W-1:0] mem_addr_q;
    logic [DATA_W-1:0] mem_wdata_q;
    logic              proc_enable_q, proc_start_q, err_q;
    logic              xfer;
    logic              hdr_valid;
    logic              last_word;

    assign xfer      = in_valid & in_ready;
    assign hdr_valid = hdr_ok(in_data[15:0]);
    assign last_word = (cnt_q == {{ADDR_W{1'b0}}, 1'b1});

    // State register
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_q <= StIdle;
        end else begin
            state_q <= state_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            StIdle:  if (xfer && hdr_valid) state_d = StLen;
            StLen:   if (xfer) state_d = StData;
            StData:  if (xfer && last_word) state_d = StFlush;
            StFlush: state_d = StDone;
            StDone:  state_d = StIdle;
            default: state_d = StIdle;
        endcase
    end

    // Handshake and status outputs decoded from state
    always_comb begin
        // alive_q keeps in_ready low while reset is held and until the first edge afterwards
        in_ready = alive_q && (state_q == StIdle || state_q == StLen || state_q == StData);
        busy     = (state_q == StLen || state_q == StData || state_q == StFlush);
    end

    // Datapath: header latch, counters, registered write port and processor controls
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            alive_q       <= 1'b0;
            tgt_q         <= TGT_IMEM;
            auto_q        <= 1'b0;
            addr_q        <= '0;
            cnt_q         <= '0;
            imem_we_q     <= 1'b0;
            dmem_we_q     <= 1'b0;
            mem_addr_q    <= '0;
            mem_wdata_q   <= '0;
            proc_enable_q <= 1'b0;
            proc_start_q  <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            alive_q      <= 1'b1;
            imem_we_q    <= 1'b0;
            dmem_we_q    <= 1'b0;
            proc_start_q <= 1'b0;
            case (state_q)
                StIdle: begin
                    if (xfer) begin
                        if (hdr_valid) begin
                            tgt_q         <= in_data[TGT_BIT];
                            auto_q        <= in_data[AUTO_BIT];
                            addr_q        <= in_data[ADDR_W-1:0];
                            err_q         <= 1'b0;
                            proc_enable_q <= 1'b0;
                        end else begin
                            err_q <= 1'b1;
                        end
                    end
                end
                StLen: begin
                    if (xfer) begin
                        cnt_q <= {1'b0, in_data[ADDR_W-1:0]} + {{ADDR_W{1'b0}}, 1'b1};
                    end
                end
                StData: begin
                    if (xfer) begin
                        imem_we_q   <= (tgt_q == TGT_IMEM);
                        dmem_we_q   <= (tgt_q == TGT_DMEM);
                        mem_addr_q  <= addr_q;
                        mem_wdata_q <= in_data;
                        addr_q      <= addr_q + {{(ADDR_W-1){1'b0}}, 1'b1};
                        cnt_q       <= cnt_q - {{ADDR_W{1'b0}}, 1'b1};
                    end
                end
                StFlush: begin
                    // Registered here so both become visible during DONE
                    proc_enable_q <= 1'b1;
                    proc_start_q  <= auto_q;
                end
                default: ;
            endcase
        end
    end

    assign imem_we     = imem_we_q;
    assign dmem_we     = dmem_we_q;
    assign mem_addr    = mem_addr_q;
    assign mem_wdata   = mem_wdata_q;
    assign proc_enable = proc_enable_q;
    assign proc_start  = proc_start_q;
    assign err         = err_q;

endmodule

// File: tb/tb_mem_loader.sv
// Scoreboard bench for mem_loader: expected writes are queued by the stimulus, and a monitor
// checks them off as write strobes appear.
module tb_mem_loader;

    logic        clock;
    logic        reset;
    logic [15:0] in_data;
    logic        in_valid;
    logic        in_ready;
    logic        imem_we;
    logic        dmem_we;
    logic [7:0]  mem_addr;
    logic [15:0] mem_wdata;
    logic        proc_enable;
    logic        proc_start;
    logic        busy;
    logic        err;

    typedef struct packed {
        logic        tgt;
        logic [7:0]  addr;
        logic [15:0] data;
    } wr_t;

    wr_t exp_q[$];
    wr_t mon_e;
    int  n_checks   = 0;
    int  n_pass     = 0;
    int  wr_seen    = 0;
    int  start_seen = 0;

    mem_loader #(
        .DATA_W(16),
        .ADDR_W(8)
    ) dut (
        .clock      (clock),
        .reset      (reset),
        .in_data    (in_data),
        .in_valid   (in_valid),
        .in_ready   (in_ready),
        .imem_we    (imem_we),
        .dmem_we    (dmem_we),
        .mem_addr   (mem_addr),
        .mem_wdata  (mem_wdata),
        .proc_enable(proc_enable),
        .proc_start (proc_start),
        .busy       (busy),
        .err        (err)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_checks++;
        if (act === exp) n_pass++;
        else $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    endtask

    // Monitor: every visible strobe must match the head of the expected-write queue.
    always @(negedge clock) begin
        if (imem_we || dmem_we) begin
            wr_seen++;
            check("we_exclusive", {31'b0, imem_we & dmem_we}, 32'd0);
            check("wr_expected", {31'b0, exp_q.size() > 0}, 32'd1);
            if (exp_q.size() > 0) begin
                mon_e = exp_q.pop_front();
                check("wr_target", {31'b0, dmem_we}, {31'b0, mon_e.tgt});
                check("wr_addr", {24'b0, mem_addr}, {24'b0, mon_e.addr});
                check("wr_data", {16'b0, mem_wdata}, {16'b0, mon_e.data});
            end
        end
        if (proc_start) start_seen++;
    end

    task automatic expect_wr(input logic tgt, input logic [7:0] addr, input logic [15:0] data);
        wr_t e;
        e.tgt  = tgt;
        e.addr = addr;
        e.data = data;
        exp_q.push_back(e);
    endtask

    // Called at a negedge; returns at the negedge after the word was accepted, valid still high.
    task automatic send(input logic [15:0] w);
        bit done;
        done     = 1'b0;
        in_data  = w;
        in_valid = 1'b1;
        for (int i = 0; i < 50 && !done; i++) begin
            if (in_ready) begin
                @(posedge clock);
                done = 1'b1;
            end
            @(negedge clock);
        end
        check("send_accepted", {31'b0, done}, 32'd1);
    endtask

    // Called at the negedge right after the last data accept (FLUSH cycle).
    task automatic finish_load(input logic exp_start);
        check("flush_ready", {31'b0, in_ready}, 32'd0);
        check("flush_busy", {31'b0, busy}, 32'd1);
        check("flush_start", {31'b0, proc_start}, 32'd0);
        @(negedge clock);
        check("done_ready", {31'b0, in_ready}, 32'd0);
        check("done_busy", {31'b0, busy}, 32'd0);
        check("done_enable", {31'b0, proc_enable}, 32'd1);
        check("done_start", {31'b0, proc_start}, {31'b0, exp_start});
        @(negedge clock);
        check("idle_ready", {31'b0, in_ready}, 32'd1);
        check("idle_start", {31'b0, proc_start}, 32'd0);
        check("idle_enable", {31'b0, proc_enable}, 32'd1);
        check("queue_drained", exp_q.size(), 32'd0);
    endtask

    task automatic check_all_zero(input string tag);
        check({tag, "_ready"}, {31'b0, in_ready}, 32'd0);
        check({tag, "_we"}, {30'b0, imem_we, dmem_we}, 32'd0);
        check({tag, "_addr"}, {24'b0, mem_addr}, 32'd0);
        check({tag, "_wdata"}, {16'b0, mem_wdata}, 32'd0);
        check({tag, "_ctrl"}, {28'b0, proc_enable, proc_start, busy, err}, 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL global_timeout: simulation did not finish in time");
        $fatal(1, "timeout");
    end

    initial begin
        int w0, s0;
        reset    = 1'b0;
        in_valid = 1'b0;
        in_data  = '0;
        #1;
        check_all_zero("reset");
        repeat (2) @(negedge clock);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("post_reset_ready", {31'b0, in_ready}, 32'd1);
        check("post_reset_busy", {31'b0, busy}, 32'd0);

        // imem load with auto-start, valid held high throughout
        w0 = wr_seen;
        s0 = start_seen;
        expect_wr(1'b0, 8'h10, 16'hA001);
        expect_wr(1'b0, 8'h11, 16'hA002);
        expect_wr(1'b0, 8'h12, 16'hA003);
        send(16'h4010);
        check("t1_len_busy", {31'b0, busy}, 32'd1);
        check("t1_len_enable", {31'b0, proc_enable}, 32'd0);
        send(16'h0002);
        send(16'hA001);
        send(16'hA002);
        send(16'hA003);
        in_valid = 1'b0;
        finish_load(1'b1);
        check("t1_writes", wr_seen - w0, 32'd3);
        check("t1_starts", start_seen - s0, 32'd1);

        // dmem load with address wrap, no auto-start
        w0 = wr_seen;
        s0 = start_seen;
        expect_wr(1'b1, 8'hFE, 16'd1);
        expect_wr(1'b1, 8'hFF, 16'd2);
        expect_wr(1'b1, 8'h00, 16'd3);
        expect_wr(1'b1, 8'h01, 16'd4);
        send(16'h80FE);
        check("t2_len_enable", {31'b0, proc_enable}, 32'd0);
        send(16'h0003);
        for (int i = 1; i <= 4; i++) send(16'(i));
        in_valid = 1'b0;
        finish_load(1'b0);
        check("t2_writes", wr_seen - w0, 32'd4);
        check("t2_starts", start_seen - s0, 32'd0);

        // gapped valid during DATA
        w0 = wr_seen;
        expect_wr(1'b1, 8'h40, 16'h0C01);
        expect_wr(1'b1, 8'h41, 16'h0C02);
        expect_wr(1'b1, 8'h42, 16'h0C03);
        send(16'h8040);
        send(16'h0002);
        for (int i = 1; i <= 2; i++) begin
            send(16'h0C00 + 16'(i));
            in_valid = 1'b0;
            @(negedge clock);
            check("t3_gap_no_strobe", {30'b0, imem_we, dmem_we}, 32'd0);
            check("t3_gap_busy", {31'b0, busy}, 32'd1);
        end
        send(16'h0C03);
        in_valid = 1'b0;
        finish_load(1'b0);
        check("t3_writes", wr_seen - w0, 32'd3);

        // bad header, then a good header clears err
        w0 = wr_seen;
        send(16'h0100);
        in_valid = 1'b0;
        check("t4_err_set", {31'b0, err}, 32'd1);
        check("t4_ready", {31'b0, in_ready}, 32'd1);
        check("t4_busy", {31'b0, busy}, 32'd0);
        @(negedge clock);
        check("t4_err_sticky", {31'b0, err}, 32'd1);
        check("t4_no_writes", wr_seen - w0, 32'd0);
        expect_wr(1'b0, 8'h00, 16'h1234);
        send(16'h0000);
        check("t4_err_cleared", {31'b0, err}, 32'd0);
        check("t4_len_busy", {31'b0, busy}, 32'd1);
        send(16'h0000);
        send(16'h1234);
        in_valid = 1'b0;
        finish_load(1'b0);
        check("t4_writes", wr_seen - w0, 32'd1);

        // full 256-word imem load starting at 0x20
        w0 = wr_seen;
        for (int i = 0; i < 256; i++) expect_wr(1'b0, 8'(8'h20 + i), 16'h5000 + 16'(i));
        send(16'h0020);
        send(16'h00FF);
        for (int i = 0; i < 256; i++) send(16'h5000 + 16'(i));
        in_valid = 1'b0;
        finish_load(1'b0);
        check("t5_writes", wr_seen - w0, 32'd256);

        // reset in the middle of DATA
        expect_wr(1'b1, 8'h00, 16'h0011);
        expect_wr(1'b1, 8'h00 + 8'd1, 16'h0022);
        send(16'h8000);
        send(16'h0003);
        send(16'h0011);
        send(16'h0022);
        #2;
        reset    = 1'b0;
        in_valid = 1'b0;
        #1;
        check_all_zero("midreset");
        exp_q.delete();
        w0 = wr_seen;
        repeat (2) @(negedge clock);
        check("t6_no_strobes_in_reset", wr_seen - w0, 32'd0);
        reset = 1'b1;
        repeat (2) @(negedge clock);
        check("t6_ready_again", {31'b0, in_ready}, 32'd1);
        check("t6_enable_low", {31'b0, proc_enable}, 32'd0);
        w0 = wr_seen;
        expect_wr(1'b1, 8'h05, 16'hBEEF);
        send(16'h8005);
        send(16'h0000);
        send(16'hBEEF);
        in_valid = 1'b0;
        finish_load(1'b0);
        check("t6_writes", wr_seen - w0, 32'd1);

        $display("%0d/%0d checks passed", n_pass, n_checks);
        $finish;
    end

endmodule
